// File: rtl/priority_arbiter_reg.sv
// priority_arbiter_reg: registered priority arbiter with a valid/ready grant stage and accept counter.
// Define RR_PRIORITY_EN for round-robin priority; default build uses fixed priority (highest index wins).
module priority_arbiter_reg #(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             gnt_valid,
    output logic [IDXW-1:0]  gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic [CNT_W-1:0] gnt_count
);

    logic             gnt_valid_q, gnt_valid_d;
    logic [IDXW-1:0]  gnt_idx_q, gnt_idx_d;
    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic [CNT_W-1:0] gnt_count_q, gnt_count_d;
    logic             slot_free;
    logic             accept;
    logic [IDXW-1:0]  sel_idx;

    assign slot_free = !gnt_valid_q || out_ready;
    assign accept    = gnt_valid_q && out_ready;

`ifdef RR_PRIORITY_EN
    localparam logic [IDXW-1:0] PTR_TOP = IDXW'(N - 1);

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] cand;
    logic            found;

    // The pointer advanced by this cycle's accept also steers the same-cycle load,
    // so back-to-back grants rotate instead of repeating the accepted index.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx_q == '0) ? PTR_TOP : gnt_idx_q - IDXW'(1);
        end
        sel_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (32'(ptr_d) >= off) begin
                cand = IDXW'(32'(ptr_d) - off);
            end else begin
                cand = IDXW'(32'(ptr_d) + N - off);
            end
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_TOP;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                sel_idx = IDXW'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_count_d  = gnt_count_q;
        if (accept) begin
            gnt_count_d = gnt_count_q + CNT_W'(1);
        end
        if (slot_free) begin
            if (|req) begin
                gnt_valid_d           = 1'b1;
                gnt_idx_d             = sel_idx;
                gnt_onehot_d          = '0;
                gnt_onehot_d[sel_idx] = 1'b1;
            end else begin
                gnt_valid_d  = 1'b0;
                gnt_idx_d    = '0;
                gnt_onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            gnt_count_q  <= '0;
        end else begin
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_count_q  <= gnt_count_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_count  = gnt_count_q;

endmodule

// File: tb/tb_priority_arbiter_reg.sv
// Self-checking bench for priority_arbiter_reg (N=8); a second instance with CNT_W=4 checks counter wrap.
module tb_priority_arbiter_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req = '0;
    logic        out_ready = 1'b0;
    logic        gnt_valid;
    logic [2:0]  gnt_idx;
    logic [7:0]  gnt_onehot;
    logic [15:0] gnt_count;
    logic        w_valid;
    logic [2:0]  w_idx;
    logic [7:0]  w_onehot;
    logic [3:0]  w_count;

    always #5 clk = ~clk;

    priority_arbiter_reg #(.N(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot), .gnt_count(gnt_count)
    );

    priority_arbiter_reg #(.N(8), .CNT_W(4)) u_w (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt_valid(w_valid), .gnt_idx(w_idx), .gnt_onehot(w_onehot), .gnt_count(w_count)
    );

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        int         eidx;
        int         ecnt;
    } vec_t;

    typedef struct {
        logic        valid;
        int          idx;
        logic [15:0] count;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic        m_valid;
    int          m_idx;
    logic [15:0] m_count;
    int          m_ptr;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start - k + 8) % 8;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_count = '0;
        m_ptr   = 7;
    endtask

    task automatic model_next(input logic [7:0] r, input logic rdy);
        bit acc, free;
        int start;
        acc   = m_valid && rdy;
        free  = !m_valid || rdy;
        start = 7;
`ifdef RR_PRIORITY_EN
        if (acc) m_ptr = (m_idx == 0) ? 7 : m_idx - 1;
        start = m_ptr;
`endif
        if (acc) m_count = m_count + 16'd1;
        if (free) begin
            if (r == 8'h00) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end else begin
                m_valid = 1'b1;
                m_idx   = pick(r, start);
            end
        end
    endtask

    // Called at a negedge: drive inputs, push expectation, compare after the next rising edge.
    task automatic cycle(input logic [7:0] r, input logic rdy, input exp_t e);
        exp_t       got;
        logic [7:0] oh;
        req       = r;
        out_ready = rdy;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (q.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            got = q.pop_front();
            oh  = '0;
            if (got.valid) oh[got.idx] = 1'b1;
            chk("gnt_valid", int'(gnt_valid), int'(got.valid));
            chk("gnt_idx", int'(gnt_idx), got.idx);
            chk("gnt_onehot", int'(gnt_onehot), int'(oh));
            chk("gnt_count", int'(gnt_count), int'(got.count));
            chk("w_count", int'(w_count), int'(got.count[3:0]));
        end
    endtask

    task automatic model_cycle(input logic [7:0] r, input logic rdy);
        exp_t e;
        model_next(r, rdy);
        e.valid = m_valid;
        e.idx   = m_idx;
        e.count = m_count;
        cycle(r, rdy, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[15];
    int   seq[9];

    initial begin
        exp_t e;
        // Expectations chosen to hold for both fixed and round-robin builds.
        tbl[0]  = '{8'h26, 1'b1, 1'b1, 5, 0};
        tbl[1]  = '{8'h80, 1'b0, 1'b1, 5, 0};
        tbl[2]  = '{8'h80, 1'b0, 1'b1, 5, 0};
        tbl[3]  = '{8'h80, 1'b0, 1'b1, 5, 0};
        tbl[4]  = '{8'h80, 1'b1, 1'b1, 7, 1};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 0, 2};
        tbl[6]  = '{8'h00, 1'b1, 1'b0, 0, 2};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 0, 2};
        tbl[8]  = '{8'h03, 1'b0, 1'b1, 1, 2};
        tbl[9]  = '{8'h01, 1'b0, 1'b1, 1, 2};
        tbl[10] = '{8'h01, 1'b1, 1'b1, 0, 3};
        tbl[11] = '{8'h81, 1'b1, 1'b1, 7, 4};
        tbl[12] = '{8'h7F, 1'b1, 1'b1, 6, 5};
        tbl[13] = '{8'h40, 1'b1, 1'b1, 6, 6};
        tbl[14] = '{8'h00, 1'b1, 1'b0, 0, 7};
`ifdef RR_PRIORITY_EN
        seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
        seq = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif

        do_reset();
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        chk("rst_onehot", int'(gnt_onehot), 0);
        chk("rst_count", int'(gnt_count), 0);

        for (int i = 0; i < 15; i++) begin
            model_next(tbl[i].req, tbl[i].rdy);
            e.valid = tbl[i].ev;
            e.idx   = tbl[i].eidx;
            e.count = 16'(tbl[i].ecnt);
            cycle(tbl[i].req, tbl[i].rdy, e);
        end

        do_reset();
        for (int i = 0; i < 9; i++) begin
            model_cycle(8'hFF, 1'b1);
            chk("rr_seq", int'(gnt_idx), seq[i]);
        end

        do_reset();
        for (int i = 1; i <= 17; i++) begin
            model_cycle(8'h01, 1'b1);
            if (i == 16) chk("wrap15", int'(w_count), 15);
            if (i == 17) chk("wrap0", int'(w_count), 0);
        end

        do_reset();
        model_cycle(8'hFF, 1'b1);
        model_cycle(8'hFF, 1'b1);
        model_cycle(8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(gnt_valid), 0);
        chk("async_idx", int'(gnt_idx), 0);
        chk("async_onehot", int'(gnt_onehot), 0);
        chk("async_count", int'(gnt_count), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_cycle(8'hFF, 1'b1);
        chk("post_rst_idx", int'(gnt_idx), 7);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] r;
            logic       rdy;
            r   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            rdy = ($urandom_range(0, 3) != 0);
            model_cycle(r, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
